// File: rtl/pe0_ntt_ctrl.sv
// rtl/pe0_ntt_ctrl.sv - pe0 butterfly sequencer for a 256-point ML-KEM NTT/INTT
// Issues 7 layers x 128 butterflies with inter-layer drain bubbles and a delayed write port.
module pe0_ntt_ctrl #(
    parameter int RD_LAT = 1,
    parameter int PE_LAT = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       mode_i,
    input  logic       hold_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       rd_en_o,
    output logic [7:0] rd_addr_a_o,
    output logic [7:0] rd_addr_b_o,
    output logic [6:0] zeta_idx_o,
    output logic [3:0] pe_ctrl_o,
    output logic       pe_valid_o,
    output logic       wr_en_o,
    output logic [7:0] wr_addr_a_o,
    output logic [7:0] wr_addr_b_o
);

    localparam int          D         = RD_LAT + PE_LAT;
    localparam logic [3:0]  DRAIN_CNT = 4'(D - 1);
    localparam logic [3:0]  FLUSH_CNT = 4'(D);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FLUSH} state_t;

    state_t      state_q;
    logic        mode_q;
    logic [7:0]  j_q;
    logic [7:0]  start_q;
    logic [7:0]  len_q;
    logic [6:0]  k_q;
    logic [3:0]  cnt_q;
    logic        done_q;

    logic        rd_en;
    logic [8:0]  j_inc;
    logic [8:0]  start_d;
    logic        blk_end;
    logic        layer_end;
    logic        last_layer;
    logic        final_bf;

    assign rd_en      = (state_q == ISSUE) && !hold_i;
    assign j_inc      = {1'b0, j_q} + 9'd1;
    assign start_d    = {1'b0, start_q} + {len_q, 1'b0};
    assign blk_end    = (j_inc == ({1'b0, start_q} + {1'b0, len_q}));
    // A layer's last block always ends exactly at index 256, so bit 8 flags it.
    assign layer_end  = blk_end && start_d[8];
    assign last_layer = mode_q ? (len_q == 8'd128) : (len_q == 8'd2);
    assign final_bf   = layer_end && last_layer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            j_q     <= '0;
            start_q <= '0;
            len_q   <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        mode_q  <= mode_i;
                        j_q     <= '0;
                        start_q <= '0;
                        len_q   <= mode_i ? 8'd2 : 8'd128;
                        k_q     <= mode_i ? 7'd127 : 7'd1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!hold_i) begin
                        if (blk_end) begin
                            if (layer_end) begin
                                j_q     <= '0;
                                start_q <= '0;
                                if (final_bf) begin
                                    cnt_q   <= FLUSH_CNT;
                                    state_q <= FLUSH;
                                end else begin
                                    len_q   <= mode_q ? (len_q << 1) : (len_q >> 1);
                                    cnt_q   <= DRAIN_CNT;
                                    state_q <= DRAIN;
                                end
                            end else begin
                                j_q     <= start_d[7:0];
                                start_q <= start_d[7:0];
                            end
                            // k stops on its terminal value instead of stepping past it.
                            if (!final_bf) begin
                                k_q <= mode_q ? (k_q - 7'd1) : (k_q + 7'd1);
                            end
                        end else begin
                            j_q <= j_inc[7:0];
                        end
                    end
                end
                DRAIN: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= ISSUE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                FLUSH: begin
                    if (cnt_q == 4'd1) begin
                        done_q <= 1'b1;
                    end
                    if (cnt_q == 4'd0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic [D-1:0]      pen_q;
    logic [D-1:0][7:0] pa_q;
    logic [D-1:0][7:0] pb_q;

    // Read-to-write delay line; the tap at RD_LAT-1 is the pe0 valid strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pen_q <= '0;
            pa_q  <= '0;
            pb_q  <= '0;
        end else begin
            pen_q[0] <= rd_en;
            pa_q[0]  <= rd_addr_a_o;
            pb_q[0]  <= rd_addr_b_o;
            for (int i = 1; i < D; i++) begin
                pen_q[i] <= pen_q[i-1];
                pa_q[i]  <= pa_q[i-1];
                pb_q[i]  <= pb_q[i-1];
            end
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign rd_en_o     = rd_en;
    assign rd_addr_a_o = j_q;
    assign rd_addr_b_o = j_q + len_q;
    assign zeta_idx_o  = k_q;
    assign pe_ctrl_o   = {3'b000, mode_q};
    assign pe_valid_o  = pen_q[RD_LAT-1];
    assign wr_en_o     = pen_q[D-1];
    assign wr_addr_a_o = pa_q[D-1];
    assign wr_addr_b_o = pb_q[D-1];

endmodule
